// File: rtl/tmds_rgb_encoder.sv
// DVI 1.0 TMDS encoder: three 8b/10b lanes with independent running disparity.
// Blue carries HSYNC/VSYNC during blanking; fixed two-clock latency, no handshake.

module tmds_lane_enc (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] d_i,
  input  logic       de_i,   // aligned with stage 1
  input  logic [1:0] ctl_i,  // aligned with stage 1
  output logic [9:0] tmds_o
);

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  logic [3:0] n1_d;
  logic       use_xnor;
  logic [8:0] qm_d, qm_q;
  logic [3:0] n1q_q;

  // Stage 1: transition-minimising chain
  always_comb begin
    n1_d     = ones8(d_i);
    use_xnor = (n1_d > 4'd4) || (n1_d == 4'd4 && !d_i[0]);
    qm_d     = '0;
    qm_d[0]  = d_i[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d_i[i]) : (qm_d[i-1] ^ d_i[i]);
    qm_d[8]  = ~use_xnor;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      qm_q  <= '0;
      n1q_q <= '0;
    end else begin
      qm_q  <= qm_d;
      n1q_q <= ones8(qm_d[7:0]);
    end
  end

  logic signed [4:0] cnt_q, cnt_d;
  logic signed [5:0] disp, cnt_x, sum;
  logic [9:0]        tmds_d;
  logic              q8;
  logic [7:0]        qd;

  // Stage 2: DC balancing; disp = N1q - N0q, computed one bit wider than cnt
  always_comb begin
    q8     = qm_q[8];
    qd     = qm_q[7:0];
    disp   = $signed({1'b0, n1q_q, 1'b0}) - 6'sd8;
    cnt_x  = {cnt_q[4], cnt_q};
    sum    = '0;
    tmds_d = 10'b1101010100;
    if (!de_i) begin
      case (ctl_i)
        2'b00:   tmds_d = 10'b1101010100;
        2'b01:   tmds_d = 10'b0010101011;
        2'b10:   tmds_d = 10'b0101010100;
        default: tmds_d = 10'b1010101011;
      endcase
    end else if (cnt_q == 5'sd0 || n1q_q == 4'd4) begin
      tmds_d = {~q8, q8, q8 ? qd : ~qd};
      sum    = q8 ? (cnt_x + disp) : (cnt_x - disp);
    end else if ((!cnt_q[4] && n1q_q > 4'd4) || (cnt_q[4] && n1q_q < 4'd4)) begin
      tmds_d = {1'b1, q8, ~qd};
      sum    = cnt_x + (q8 ? 6'sd2 : 6'sd0) - disp;
    end else begin
      tmds_d = {1'b0, q8, qd};
      sum    = cnt_x + disp - (q8 ? 6'sd0 : 6'sd2);
    end
    cnt_d = sum[4:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tmds_o <= 10'h354;
    end else begin
      cnt_q  <= cnt_d;
      tmds_o <= tmds_d;
    end
  end

endmodule

module tmds_rgb_encoder #(
  parameter logic HS_INV = 1'b0,
  parameter logic VS_INV = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] red_i,
  input  logic [7:0] green_i,
  input  logic [7:0] blue_i,
  input  logic       px_valid_i,
  input  logic       h_sync_i,
  input  logic       v_sync_i,
  output logic [9:0] tmds_red_o,
  output logic [9:0] tmds_green_o,
  output logic [9:0] tmds_blue_o
);

  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0][7:0] lane_d;
  logic [NUM_LANES-1:0][1:0] lane_c, lane_c_q;
  logic [NUM_LANES-1:0][9:0] lane_q;
  logic                      de_q;

  // Lane 0 = blue (sync carrier), 1 = green, 2 = red
  assign lane_d = {red_i, green_i, blue_i};
  assign lane_c = {2'b00, 2'b00, {v_sync_i ^ VS_INV, h_sync_i ^ HS_INV}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      de_q     <= 1'b0;
      lane_c_q <= '0;
    end else begin
      de_q     <= px_valid_i;
      lane_c_q <= lane_c;
    end
  end

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      tmds_lane_enc u_enc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (lane_d[l]),
        .de_i   (de_q),
        .ctl_i  (lane_c_q[l]),
        .tmds_o (lane_q[l])
      );
    end
  endgenerate

  assign tmds_blue_o  = lane_q[0];
  assign tmds_green_o = lane_q[1];
  assign tmds_red_o   = lane_q[2];

endmodule

// File: tb/tb_tmds_rgb_encoder.sv
// Scoreboard bench for tmds_rgb_encoder: directed vectors with hand-derived
// characters, then random bursts checked by decoding and disparity tracking.

module tb_tmds_rgb_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] red, green, blue;
  logic       de, hs, vs;
  logic [9:0] r_o, g_o, b_o, r2_o, g2_o, b2_o;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  int vid   = 0;
  int cnt [3];

  typedef struct {
    int         due;
    int         id;
    bit         exact;
    bit         de;
    bit         h;
    bit         v;
    logic [7:0] dr, dg, db;
    logic [9:0] er, eg, eb, ebi;
    bit         chk_cnt;
    int         ecnt;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  tmds_rgb_encoder dut (
    .clk_i(clk), .rst_i(rst), .red_i(red), .green_i(green), .blue_i(blue),
    .px_valid_i(de), .h_sync_i(hs), .v_sync_i(vs),
    .tmds_red_o(r_o), .tmds_green_o(g_o), .tmds_blue_o(b_o)
  );

  tmds_rgb_encoder #(.HS_INV(1'b1), .VS_INV(1'b0)) dut_inv (
    .clk_i(clk), .rst_i(rst), .red_i(red), .green_i(green), .blue_i(blue),
    .px_valid_i(de), .h_sync_i(hs), .v_sync_i(vs),
    .tmds_red_o(r2_o), .tmds_green_o(g2_o), .tmds_blue_o(b2_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] w);
    logic [7:0] d, o;
    d    = w[9] ? ~w[7:0] : w[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  function automatic int disp(input logic [9:0] w);
    return 2 * $countones(w) - 10;
  endfunction

  task automatic chk(input string nm, input int id, input logic [9:0] act, input logic [9:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, want);
    end
  endtask

  task automatic check(input exp_t e);
    logic [9:0] w [3];
    w[0] = b_o; w[1] = g_o; w[2] = r_o;
    if (e.exact) begin
      chk("red", e.id, r_o, e.er);
      chk("green", e.id, g_o, e.eg);
      chk("blue", e.id, b_o, e.eb);
      chk("red_inv", e.id, r2_o, e.er);
      chk("blue_inv", e.id, b2_o, e.ebi);
    end else if (e.de) begin
      chk("dec_red", e.id, {2'b00, dec(r_o)}, {2'b00, e.dr});
      chk("dec_green", e.id, {2'b00, dec(g_o)}, {2'b00, e.dg});
      chk("dec_blue", e.id, {2'b00, dec(b_o)}, {2'b00, e.db});
      chk("dec_green_inv", e.id, {2'b00, dec(g2_o)}, {2'b00, e.dg});
      chk("dec_blue_inv", e.id, {2'b00, dec(b2_o)}, {2'b00, e.db});
    end else begin
      chk("tok_red", e.id, r_o, 10'h354);
      chk("tok_green", e.id, g_o, 10'h354);
      chk("tok_blue", e.id, b_o, tok({e.v, e.h}));
      chk("tok_green_inv", e.id, g2_o, 10'h354);
      chk("tok_blue_inv", e.id, b2_o, tok({e.v, ~e.h}));
    end
    // Running disparity of the transmitted stream, reset by every control character
    for (int ch = 0; ch < 3; ch++) begin
      if (e.de) begin
        cnt[ch] = cnt[ch] + disp(w[ch]);
        total++;
        if (cnt[ch] > 8 || cnt[ch] < -8 || (cnt[ch] % 2) != 0) begin
          bad++;
          $display("FAIL disparity ch%0d vec%0d: got %0d expected even within +-8", ch, e.id, cnt[ch]);
        end
      end else begin
        cnt[ch] = 0;
      end
    end
    if (e.chk_cnt) begin
      total++;
      if (cnt[0] != e.ecnt) begin
        bad++;
        $display("FAIL cnt_blue vec%0d: got %0d expected %0d", e.id, cnt[0], e.ecnt);
      end
    end
  endtask

  task automatic push(input exp_t e);
    e.due = cyc + 2;
    e.id  = vid;
    vid++;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vx(input logic d, input logic [7:0] r, g, b, input logic h, v,
                    input logic [9:0] er, eg, eb, ebi, input int ec);
    exp_t e;
    de = d; red = r; green = g; blue = b; hs = h; vs = v;
    e.exact = 1'b1; e.de = d; e.h = h; e.v = v;
    e.dr = r; e.dg = g; e.db = b;
    e.er = er; e.eg = eg; e.eb = eb; e.ebi = ebi;
    e.chk_cnt = 1'b1; e.ecnt = ec;
    push(e);
  endtask

  task automatic vr(input logic d, input logic [7:0] r, g, b, input logic h, v);
    exp_t e;
    de = d; red = r; green = g; blue = b; hs = h; vs = v;
    e.exact = 1'b0; e.de = d; e.h = h; e.v = v;
    e.dr = r; e.dg = g; e.db = b;
    e.er = '0; e.eg = '0; e.eb = '0; e.ebi = '0;
    e.chk_cnt = 1'b0; e.ecnt = 0;
    push(e);
  endtask

  task automatic vtok(input logic h, v, input logic [9:0] eb, ebi);
    vx(1'b0, 8'h00, 8'h00, 8'h00, h, v, 10'h354, 10'h354, eb, ebi, 0);
  endtask

  task automatic vdat(input logic [7:0] x, input logic [9:0] w, input int ec);
    vx(1'b1, x, x, x, 1'b0, 1'b0, w, w, w, w, ec);
  endtask

  task automatic rst_check(input string nm);
    chk({nm, "_red"}, vid, r_o, 10'h354);
    chk({nm, "_green"}, vid, g_o, 10'h354);
    chk({nm, "_blue"}, vid, b_o, 10'h354);
    chk({nm, "_red_inv"}, vid, r2_o, 10'h354);
    chk({nm, "_green_inv"}, vid, g2_o, 10'h354);
    chk({nm, "_blue_inv"}, vid, b2_o, 10'h354);
  endtask

  // Monitor: every pixel yields one output character set, two clocks later
  initial forever begin
    @(negedge clk);
    if (!rst && sb.size() > 0) begin
      if (sb[0].due < cyc) begin
        me = sb.pop_front();
        total++;
        bad++;
        $display("FAIL stale vec%0d: due %0d now %0d", me.id, me.due, cyc);
      end else if (sb[0].due == cyc) begin
        me = sb.pop_front();
        check(me);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic de_r;
    red = '0; green = '0; blue = '0; de = 1'b0; hs = 1'b0; vs = 1'b0;
    for (int ch = 0; ch < 3; ch++) cnt[ch] = 0;
    #1 rst = 1'b1;
    #2 rst_check("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    tick(); vtok(1'b0, 1'b0, 10'h354, 10'h0AB);
    tick(); vtok(1'b0, 1'b0, 10'h354, 10'h0AB);
    tick(); vdat(8'h00, 10'h100, -8);
    tick(); vdat(8'h00, 10'h3FF, 2);
    tick(); vdat(8'h00, 10'h100, -6);
    tick(); vtok(1'b0, 1'b0, 10'h354, 10'h0AB);
    tick(); vdat(8'hFF, 10'h200, -8);
    tick(); vtok(1'b0, 1'b0, 10'h354, 10'h0AB);
    tick(); vdat(8'h00, 10'h100, -8);
    tick(); vtok(1'b1, 1'b0, 10'h0AB, 10'h354);
    tick(); vtok(1'b0, 1'b1, 10'h154, 10'h2AB);
    tick(); vtok(1'b1, 1'b1, 10'h2AB, 10'h154);
    tick(); vtok(1'b0, 1'b0, 10'h354, 10'h0AB);
    // single-pixel pulse; syncs high during DE must not leak into blue
    tick(); vx(1'b1, 8'h10, 8'h00, 8'h00, 1'b1, 1'b1, 10'h1F0, 10'h100, 10'h100, 10'h100, -8);
    tick(); vtok(1'b0, 1'b0, 10'h354, 10'h0AB);
    // N1==4 split on D[0], balanced q_m with cnt!=0, cnt reaching +8
    tick(); vdat(8'h0F, 10'h105, -4);
    tick(); vdat(8'hF0, 10'h0FA, -2);
    tick(); vdat(8'h10, 10'h1F0, -2);
    tick(); vdat(8'h00, 10'h3FF, 8);
    tick(); vdat(8'hFF, 10'h200, 0);
    tick(); vdat(8'hFF, 10'h200, -8);
    tick(); vtok(1'b0, 1'b0, 10'h354, 10'h0AB);

    // mid-stream asynchronous reset with a pixel still in flight
    tick(); vdat(8'h00, 10'h100, -8);
    tick(); vdat(8'h00, 10'h3FF, 2);
    tick(); vdat(8'h00, 10'h100, -6);
    @(posedge clk);
    #7;
    de = 1'b0;
    rst = 1'b1;
    #1 rst_check("midrst");
    sb.delete();
    for (int ch = 0; ch < 3; ch++) cnt[ch] = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    vdat(8'h00, 10'h100, -8);
    tick(); vtok(1'b0, 1'b0, 10'h354, 10'h0AB);

    de_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(0, 11) == 0) de_r = ~de_r;
      vr(de_r, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    tick(); vtok(1'b0, 1'b0, 10'h354, 10'h0AB);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
